s2p_deserializer: RTL
=====================

Name: s2p_deserializer

Overview:
- Upstream stage of the S2P datapath: collects a strobed serial bit stream into a WIDTH-bit parallel word.
- Presents each completed word on a valid/ready output port to the downstream per-bit clock-enabled register bank.
- Holds one completed word, flags overflow when a word completes with nowhere to go, and supports frame resync.

Parameters:
- WIDTH, 8, parallel word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first received bit lands in data_out[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- serial_in  input  1  serial data bit.
- bit_en  input  1  serial_in is sampled on a rising edge only when bit_en=1.
- sync  input  1  frame resync; discards the partial word.
- data_out  output  WIDTH  completed word from the holding register.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  downstream accepts data_out when data_valid=1.
- overflow  output  1  sticky; a completed word was dropped.
- ovf_clr  input  1  clears overflow.
- par_err  output  1  parity error on the word currently in data_out (see Optional Feature).

Behaviour:
- Reset: when rst=1 at an edge, shift register, bit counter, data_out, data_valid, overflow and par_err all go to 0. rst has priority over every other input, including a word completing mid-reception; any partial word is lost.
- Counter: width $clog2(WIDTH+1). Counts 0..WIDTH-1 and returns to 0 at word completion. It never exceeds WIDTH-1 (WIDTH with the parity feature enabled).
- Sampling: on an edge with bit_en=1, serial_in shifts in according to MSB_FIRST and the counter increments. With bit_en=0, the shift register and counter hold.
- Completion: on the edge where bit_en=1 and counter=WIDTH-1, the full word is the shift contents plus the current serial_in.
  - If the holding register is free (data_valid=0, or data_valid=1 and data_ready=1), the full word loads into data_out and data_valid=1 after that edge. Latency is 0 cycles after the last bit's edge.
  - If data_valid=1 and data_ready=0, the new word is dropped, data_out is unchanged and overflow is set.
  - In either case the counter wraps to 0.
- Handshake:
  - A transfer occurs on any edge with data_valid=1 and data_ready=1.
  - data_valid then clears, unless a completion loads a new word on the same edge, in which case it stays 1 and data_out updates.
  - data_out is stable while data_valid=1 and data_ready=0.
- sync: on an edge with sync=1, the counter and shift register clear and the partial word is discarded; data_out, data_valid and overflow are unaffected. If bit_en=1 on the same edge, serial_in is stored as bit 0 of the new word and the counter becomes 1.
- overflow: set by a dropped word, cleared by ovf_clr. If both happen on the same edge, set wins.
- No combinational path from any input to any output.

Optional Feature:
- Macro name: S2P_PARITY_EN.
- Defined:
  - Each word is followed by one parity bit strobed by bit_en; the counter runs 0..WIDTH.
  - Completion happens on the parity-bit edge, not the WIDTH-1 edge.
  - par_err loads with data_out and is 1 when XOR(word, parity bit) != 1 (odd parity). It is valid while data_valid=1.
  - A sync asserted before the parity bit arrives discards the word.
- Undefined: the port is still present, par_err is tied to 0, and words complete at bit WIDTH-1.

Decomposition:
- Shared include s2p_defs.vh: default WIDTH, parity sense constant (odd = 1), and the counter-width expression.
- One natural sub-module, s2p_bit_counter: holds the counter and produces the wrap/complete pulse. Inputs are bit_en, sync and rst; the terminal count is a parameter.
- Shift register, holding register and flags stay in the top level.

Test Plan:
- WIDTH=8, MSB_FIRST=1, data_ready=1, bits 1,0,1,0,0,1,0,1 strobed with gaps of idle cycles -> data_out=8'hA5 and data_valid=1 after the 8th bit edge; data_valid=0 one edge later.
- Same stream with MSB_FIRST=0 -> data_out=8'hA5 reversed, i.e. 8'hA5 bit-reversed = 8'hA5 (palindrome check); then send 8'h01 serially -> data_out=8'h80.
- data_ready=0, two full words 8'h3C then 8'hC3 -> data_out stays 8'h3C, overflow=1; pulse ovf_clr -> overflow=0; assert data_ready -> transfer, data_valid=0.
- Continuous bit_en=1, data_ready asserted exactly on each completion edge -> back-to-back words with data_valid held 1 and no overflow.
- After 5 bits, assert sync together with bit_en=1, then 7 more bits -> word consists of the sync-edge bit plus the 7 bits; the first 5 bits are discarded; rst asserted mid-word -> all outputs 0 and the next word decodes cleanly.
- With S2P_PARITY_EN, word 8'h07 followed by parity bit 0 -> par_err=0; followed by parity bit 1 -> par_err=1.

Source files
------------

// File: rtl/s2p_deserializer_pkg.sv
// Shared constants and helpers for the S2P serial-to-parallel datapath.
package s2p_deserializer_pkg;

    localparam int   S2P_DEFAULT_WIDTH = 8;
    localparam logic S2P_PARITY_SENSE  = 1'b1;

    function automatic int s2p_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // The word plus its parity bit must XOR to the parity sense.
    function automatic logic s2p_par_err(input logic [31:0] word, input logic par_bit);
        return ((^word) ^ par_bit) != S2P_PARITY_SENSE;
    endfunction

endpackage

// File: rtl/s2p_bit_counter.sv
// Bit position counter for the S2P deserializer; pulses complete on the terminal-count strobe.
module s2p_bit_counter #(
    parameter int TERMINAL = 7,
    parameter int CW       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic sync,
    output logic complete
);

    logic [CW-1:0] count_r;

    // A sync edge never completes a word, even at terminal count.
    assign complete = bit_en && !sync && (count_r == CW'(TERMINAL));

    // Counter: sync restarts the frame, counting the sync-edge bit if strobed.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CW'(0);
        end else if (sync) begin
            count_r <= bit_en ? CW'(1) : CW'(0);
        end else if (bit_en) begin
            if (count_r == CW'(TERMINAL)) begin
                count_r <= CW'(0);
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/s2p_deserializer.sv
// Serial-to-parallel deserializer with a one-word valid/ready holding register.
// Optional odd-parity checking is built when S2P_PARITY_EN is defined.
module s2p_deserializer
    import s2p_deserializer_pkg::*;
#(
    parameter int WIDTH     = S2P_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_en,
    input  logic             sync,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overflow,
    input  logic             ovf_clr,
    output logic             par_err
);

`ifdef S2P_PARITY_EN
    localparam int TERMINAL = WIDTH;
`else
    localparam int TERMINAL = WIDTH - 1;
`endif
    localparam int CW = s2p_cnt_width(WIDTH);

    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_base_s;
    logic [WIDTH-1:0] shift_next_s;
    logic [WIDTH-1:0] word_s;
    logic             par_err_s;
    logic             complete_s;
    logic             free_s;

    s2p_bit_counter #(
        .TERMINAL (TERMINAL),
        .CW       (CW)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .bit_en   (bit_en),
        .sync     (sync),
        .complete (complete_s)
    );

    // Next shift contents and the assembled word for a completing edge.
    always_comb begin
        shift_base_s = sync ? {WIDTH{1'b0}} : shift_r;
        if (MSB_FIRST) begin
            shift_next_s = {shift_base_s[WIDTH-2:0], serial_in};
        end else begin
            shift_next_s = {serial_in, shift_base_s[WIDTH-1:1]};
        end
`ifdef S2P_PARITY_EN
        word_s    = shift_r;
        par_err_s = s2p_par_err(32'(shift_r), serial_in);
`else
        word_s    = shift_next_s;
        par_err_s = 1'b0;
`endif
    end

    assign free_s = !data_valid || data_ready;

    // Shift register: cleared on completion so each frame starts empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= {WIDTH{1'b0}};
        end else if (complete_s) begin
            shift_r <= {WIDTH{1'b0}};
        end else if (bit_en) begin
            shift_r <= shift_next_s;
        end else if (sync) begin
            shift_r <= {WIDTH{1'b0}};
        end else begin
            shift_r <= shift_r;
        end
    end

    // Holding register, handshake and sticky overflow (a drop beats ovf_clr).
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= {WIDTH{1'b0}};
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            par_err    <= 1'b0;
        end else begin
            if (complete_s && free_s) begin
                data_out   <= word_s;
                data_valid <= 1'b1;
                par_err    <= par_err_s;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end else begin
                data_valid <= data_valid;
            end

            if (complete_s && !free_s) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end else begin
                overflow <= overflow;
            end
        end
    end

endmodule
